// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the capture-start controller.
//   - state_e : controller FSM states
//   - cmd_word bit positions (GO_BIT, ABORT_BIT, N_LSB)
//   - status_word bit positions (BUSY_BIT, DONE_BIT, ABORTED_BIT,
//     TIMEOUT_BIT, FRAMES_LSB)
package capture_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    PULSE      = 2'd2,
    WAIT_FRAME = 2'd3
  } state_e;

  // cmd_word layout
  localparam int unsigned GO_BIT    = 0;
  localparam int unsigned ABORT_BIT = 1;
  localparam int unsigned N_LSB     = 8;

  // status_word layout
  localparam int unsigned BUSY_BIT    = 0;
  localparam int unsigned DONE_BIT    = 1;
  localparam int unsigned ABORTED_BIT = 2;
  localparam int unsigned TIMEOUT_BIT = 3;
  localparam int unsigned FRAMES_LSB  = 8;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector built around a single history register.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset (history clears to 0)
//   d_i     - level input
//   rise_o  - high for the cycle in which d_i is 1 and was 0 at the last edge
// The history register resets to 0, so an input that is already high when
// reset is released is reported as a rising edge.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/capture_start_ctrl.sv
// Capture-start controller: turns the PIO command word into a sequenced
// start handshake with the camera capture pipeline, counts frames, applies a
// per-frame timeout and reports a status word.
// Ports:
//   clk         - clock
//   reset_n     - asynchronous active-low reset
//   cmd_word    - [0] go (rising edge), [1] abort (level), [15:8] frame count
//                 N (0 = continuous), [7:2] unused
//   cap_ready   - pipeline can accept a start
//   frame_done  - one-cycle end-of-frame pulse
//   start_pulse - registered start strobe, PULSE_LEN cycles wide
//   busy        - registered, high whenever the FSM is not in IDLE
//   status_word - {frames_done, 4'b0, timeout, aborted, done, busy}
module capture_start_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_LEN      = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cmd_word,
  input  logic        cap_ready,
  input  logic        frame_done,
  output logic        start_pulse,
  output logic        busy,
  output logic [15:0] status_word
);

  localparam logic [3:0]  PULSE_LEN_C = PULSE_LEN[3:0];
  localparam logic [23:0] TO_LAST     = TIMEOUT_CYCLES - 24'd1;

  state_e      state_q;
  logic [7:0]  n_q;
  logic [7:0]  frames_q;
  logic [7:0]  frames_d;
  logic [3:0]  pulse_cnt_q;
  logic [23:0] to_cnt_q;
  logic        done_q;
  logic        aborted_q;
  logic        timeout_q;
  logic        start_q;
  logic        busy_q;

  logic go_rise;
  logic abort;
  logic unused_cmd_bits;

  assign abort           = cmd_word[ABORT_BIT];
  assign unused_cmd_bits = ^cmd_word[7:2];
  assign frames_d        = frames_q + 8'd1;

  rise_detect u_go_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (cmd_word[GO_BIT]),
    .rise_o  (go_rise)
  );

  // busy and start_pulse are registered alongside the state so that no
  // output has a combinational path from the inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      n_q         <= 8'd0;
      frames_q    <= 8'd0;
      pulse_cnt_q <= 4'd0;
      to_cnt_q    <= 24'd0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else if (state_q != IDLE && abort) begin
      // Abort outranks every other event in the active states.
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      aborted_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A go edge coincident with abort is dropped, not deferred.
          if (go_rise && !abort) begin
            state_q   <= ARM;
            busy_q    <= 1'b1;
            n_q       <= cmd_word[N_LSB +: 8];
            frames_q  <= 8'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            timeout_q <= 1'b0;
          end
        end

        ARM: begin
          if (cap_ready) begin
            state_q     <= PULSE;
            start_q     <= 1'b1;
            pulse_cnt_q <= PULSE_LEN_C;
          end
        end

        PULSE: begin
          // Counter holds the remaining high cycles including the current one.
          if (pulse_cnt_q == 4'd1) begin
            state_q  <= WAIT_FRAME;
            start_q  <= 1'b0;
            to_cnt_q <= 24'd0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 4'd1;
          end
        end

        WAIT_FRAME: begin
          if (frame_done) begin
            frames_q <= frames_d;
            if (n_q != 8'd0 && frames_d == n_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ARM;
            end
          end else if (to_cnt_q == TO_LAST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 24'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign start_pulse = start_q;
  assign busy        = busy_q;

  // NOTE: every signal written in always_comb gets a default first so no
  // latch is inferred for bits a branch might leave unassigned.
  always_comb begin
    status_word                      = 16'h0000;
    status_word[BUSY_BIT]            = busy_q;
    status_word[DONE_BIT]            = done_q;
    status_word[ABORTED_BIT]         = aborted_q;
    status_word[TIMEOUT_BIT]         = timeout_q;
    status_word[FRAMES_LSB +: 8]     = frames_q;
  end

endmodule

// File: doc/capture_start_ctrl.md
# capture_start_ctrl

Consumes the 16-bit command word driven by the start-signal PIO output register and turns it into a sequenced capture-start handshake with the camera capture pipeline. The block issues start pulses, counts completed frames, enforces a per-frame timeout, and returns a 16-bit status word to be read back through an input PIO. It runs in the same clock domain as the PIO, so no synchronisers are needed.

## Interface

Parameters:
- PULSE_LEN, 4: width of each start pulse in clk cycles; legal range 1..15.
- TIMEOUT_CYCLES, 24'd5_000_000: maximum cycles spent in WAIT_FRAME before aborting with a timeout.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cmd_word, input, 16: PIO command word.
  - [0] go: rising edge starts a run.
  - [1] abort: level-sensitive.
  - [7:2] ignored.
  - [15:8] frame count N; 0 means continuous.
- cap_ready, input, 1: capture pipeline idle and able to accept a start.
- frame_done, input, 1: single-cycle pulse at the end of each captured frame.
- start_pulse, output, 1: registered start strobe to the capture pipeline.
- busy, output, 1: high while the state is not IDLE.
- status_word, output, 16: {frames_done[7:0], 4'b0, timeout_flag, aborted_flag, done_flag, busy}.

## Operation

- **States:** IDLE, ARM, PULSE, WAIT_FRAME.
- **go detection:** go_q is a register of cmd_word[0]. A rising edge is cmd_word[0] & ~go_q. go_q updates every cycle in every state.
- **IDLE:**
  - On a go edge with abort low: move to ARM, latch N from cmd_word[15:8], clear frames_done, and clear all three sticky flags.
  - Otherwise hold.
- **ARM:** wait for cap_ready = 1, then move to PULSE and load the pulse counter with PULSE_LEN.
- **PULSE:**
  - start_pulse is high for exactly PULSE_LEN cycles.
  - Then move to WAIT_FRAME and clear the timeout counter.
- **WAIT_FRAME:**
  - On frame_done: frames_done increments.
    - If N ≠ 0 and the new frames_done equals N: go to IDLE and set done_flag.
    - Otherwise return to ARM.
  - Else, if the timeout counter reaches TIMEOUT_CYCLES−1: go to IDLE and set timeout_flag.
  - Else the timeout counter increments.
- **Abort:** abort = 1 in any non-IDLE state forces IDLE on the next edge and sets aborted_flag. start_pulse drops on that same edge.
- **Precedence:**
  - Abort beats go; a go edge coincident with abort is discarded.
  - Abort beats frame_done.
  - frame_done beats timeout.
- **Ignored events:**
  - A go edge outside IDLE is ignored; it is not queued.
  - frame_done outside WAIT_FRAME is ignored and not counted.
- **Counter widths:**
  - frames_done is 8 bits. In continuous mode it wraps modulo 256; in counted mode it never exceeds N.
  - The timeout counter is 24 bits and never wraps, because the transition fires at terminal count.
- **Sticky flags:** set as above, held until the next accepted go, and unaffected by abort returning low.

## Timing

- **Reset values:**
  - State = IDLE.
  - start_pulse = 0, busy = 0, status_word = 16'h0000.
  - go_q = 0, so a cmd_word[0] already high when reset is released counts as an edge.
  - All counters and flags = 0.
- **All outputs are registered;** none depends combinationally on the inputs.
- **Start latency:**
  - go edge sampled at edge n → busy and ARM at n+1.
  - If cap_ready is high at n+1 → start_pulse high for cycles n+2 .. n+1+PULSE_LEN.
  - Each extra cycle with cap_ready low delays this by one cycle.
- **Frame completion:** frame_done sampled at edge m → frames_done updated at m+1. The state is ARM, or IDLE with busy low, at m+1.
- **Abort:** abort sampled at edge a → busy = 0 and start_pulse = 0 at a+1.
- **Reset mid-run:** returns everything to the reset values immediately (asynchronous), including any start_pulse in progress.

## Structure

- **Package capture_ctrl_pkg** holds:
  - The state enum (IDLE, ARM, PULSE, WAIT_FRAME).
  - Bit-index constants for cmd_word: GO_BIT = 0, ABORT_BIT = 1, N_LSB = 8.
  - Bit-index constants for status_word: BUSY_BIT = 0, DONE_BIT = 1, ABORTED_BIT = 2, TIMEOUT_BIT = 3, FRAMES_LSB = 8.
- **Sub-module rise_detect:** a 1-bit registered rising-edge detector with clk and reset_n. It is instantiated once for go.
- **Everything else** (FSM, pulse counter, timeout counter, flags) lives in the top module.

## Test plan

- **Counted run:** N = 3, PULSE_LEN = 4, cap_ready = 1, go edge, frame_done 10 cycles after each pulse → three 4-cycle start_pulses, then status_word = 16'h0302 with busy low.
- **Continuous run:** N = 0, 300 frame_done pulses, then abort → frames_done = 8'd44 (300 mod 256), aborted_flag = 1, busy = 0 one cycle after abort is sampled.
- **Timeout:** TIMEOUT_CYCLES = 100 with no frame_done → IDLE exactly 100 cycles after entering WAIT_FRAME, with timeout_flag = 1 and status_word = 16'h0008.
- **Simultaneous events:**
  - frame_done on the terminal timeout cycle → counted as a frame, timeout_flag = 0.
  - go edge together with abort while in IDLE → no start, busy stays 0.
- **Handshake and ignored go:**
  - cap_ready held low for 20 cycles → start_pulse is delayed exactly 20 cycles.
  - A second go edge while busy → no effect on N or flags.
- **Reset mid-run:** reset_n asserted during PULSE → start_pulse, busy and status_word go to 0 immediately. The first go edge after release starts a clean run.
